// File: rtl/zone_pkg.sv
// Shared definitions for the zone tracker bank and its reader.
//   COORD_W          default coordinate width (tracker hcount/vcount bounds)
//   MAX_X / MAX_Y    active frame extent in pixels
//   tracker_state_t  tracker state encoding (INACTIVE / ACTIVE)
//   reader_state_t   zone_reader FSM states
package zone_pkg;

  localparam int COORD_W = 11;
  localparam int MAX_X   = 800;
  localparam int MAX_Y   = 600;

  typedef enum logic {
    INACTIVE = 1'b0,
    ACTIVE   = 1'b1
  } tracker_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } reader_state_t;

endpackage

// File: rtl/zone_qualify.sv
// Combinational qualification and geometry of a single tracker zone.
// Optional feature macro: ZONE_READER_AREA_EN (adds area output and MIN_AREA check).
// Ports:
//   active                     tracker state bit of the zone
//   left/right/top/bottom      zone bounds
//   qualify                    zone is active, correctly ordered and large enough
//   cx/cy                      box centre
//   width/height               box size (0 when the box is inverted)
//   area                       width*height (ZONE_READER_AREA_EN only)
module zone_qualify #(
  parameter int COORD_W  = zone_pkg::COORD_W,
  parameter int MIN_SIZE = 4
`ifdef ZONE_READER_AREA_EN
  , parameter int MIN_AREA = 64
`endif
) (
  input  logic               active,
  input  logic [COORD_W-1:0] left,
  input  logic [COORD_W-1:0] right,
  input  logic [COORD_W-1:0] top,
  input  logic [COORD_W-1:0] bottom,
  output logic               qualify,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height
`ifdef ZONE_READER_AREA_EN
  , output logic [2*COORD_W-1:0] area
`endif
);
  import zone_pkg::*;

  localparam logic [COORD_W-1:0] MIN_SZ = COORD_W'(MIN_SIZE);
`ifdef ZONE_READER_AREA_EN
  localparam logic [2*COORD_W-1:0] MIN_AR = (2*COORD_W)'(MIN_AREA);
`endif

  logic [COORD_W:0] sum_x;
  logic [COORD_W:0] sum_y;
  logic             ordered;
  logic             size_ok;

  always_comb begin
    // one extra bit keeps the carry of e.g. 2047+2047 before halving
    sum_x   = {1'b0, left} + {1'b0, right};
    sum_y   = {1'b0, top} + {1'b0, bottom};
    cx      = sum_x[COORD_W:1];
    cy      = sum_y[COORD_W:1];
    ordered = (right >= left) && (bottom >= top);
    width   = '0;
    height  = '0;
    // inverted boxes never produce a wrapped size
    if (ordered) begin
      width  = right - left;
      height = bottom - top;
    end
    size_ok = ordered && (width >= MIN_SZ) && (height >= MIN_SZ);
`ifdef ZONE_READER_AREA_EN
    area    = (2*COORD_W)'(width) * (2*COORD_W)'(height);
    qualify = (active == ACTIVE) && size_ok && (area >= MIN_AR);
`else
    qualify = (active == ACTIVE) && size_ok;
`endif
  end

endmodule

// File: rtl/zone_reader.sv
// End-of-frame reader for the zone tracker bank. Snapshots every zone's
// bounding box on frame_done and streams one record per qualifying zone.
// Optional feature macro: ZONE_READER_AREA_EN (adds out_area and MIN_AREA).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   frame_done                  end-of-frame pulse, starts a readout from IDLE
//   zone_active/left/right/top/bottom   flattened per-zone tracker state
//   out_valid/out_ready         record handshake
//   out_index/cx/cy/width/height (out_area)   record fields
//   busy                        readout in progress (any state but IDLE)
//   done, zone_count            readout complete pulse and its record count
//   overrun                     frame_done arrived while busy
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for frame_done
// SCAN  | evaluating snapshot zone idx, one cycle per zone
// EMIT  | record for zone idx held on out_* until accepted
// DONE  | one-cycle completion, done high, zone_count valid
module zone_reader #(
  parameter int NUM_ZONES = 4,
  parameter int MIN_SIZE  = 4,
  parameter int COORD_W   = zone_pkg::COORD_W
`ifdef ZONE_READER_AREA_EN
  , parameter int MIN_AREA = 64
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_done,
  input  logic [NUM_ZONES-1:0]         zone_active,
  input  logic [NUM_ZONES*COORD_W-1:0] zone_left,
  input  logic [NUM_ZONES*COORD_W-1:0] zone_right,
  input  logic [NUM_ZONES*COORD_W-1:0] zone_top,
  input  logic [NUM_ZONES*COORD_W-1:0] zone_bottom,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_index,
  output logic [COORD_W-1:0]           out_cx,
  output logic [COORD_W-1:0]           out_cy,
  output logic [COORD_W-1:0]           out_width,
  output logic [COORD_W-1:0]           out_height,
`ifdef ZONE_READER_AREA_EN
  output logic [2*COORD_W-1:0]         out_area,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [4:0]                   zone_count,
  output logic                         overrun
);
  import zone_pkg::*;

  // snapshot is padded to 16 entries so the 4-bit idx always selects in range
  localparam int         MAX_ZONES = 16;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_ZONES - 1);

  reader_state_t        state, state_nxt;
  logic [3:0]           idx;
  logic [4:0]           count;
  logic                 last;

  logic [MAX_ZONES-1:0] in_active, snap_active;
  logic [COORD_W-1:0]   in_left   [MAX_ZONES];
  logic [COORD_W-1:0]   in_right  [MAX_ZONES];
  logic [COORD_W-1:0]   in_top    [MAX_ZONES];
  logic [COORD_W-1:0]   in_bottom [MAX_ZONES];
  logic [COORD_W-1:0]   snap_left   [MAX_ZONES];
  logic [COORD_W-1:0]   snap_right  [MAX_ZONES];
  logic [COORD_W-1:0]   snap_top    [MAX_ZONES];
  logic [COORD_W-1:0]   snap_bottom [MAX_ZONES];

  logic                 q_ok;
  logic [COORD_W-1:0]   q_cx, q_cy, q_w, q_h;
`ifdef ZONE_READER_AREA_EN
  logic [2*COORD_W-1:0] q_area;
`endif

  for (genvar g = 0; g < MAX_ZONES; g++) begin : g_unpack
    if (g < NUM_ZONES) begin : g_live
      assign in_active[g] = zone_active[g];
      assign in_left[g]   = zone_left[g*COORD_W +: COORD_W];
      assign in_right[g]  = zone_right[g*COORD_W +: COORD_W];
      assign in_top[g]    = zone_top[g*COORD_W +: COORD_W];
      assign in_bottom[g] = zone_bottom[g*COORD_W +: COORD_W];
    end else begin : g_pad
      assign in_active[g] = 1'b0;
      assign in_left[g]   = '0;
      assign in_right[g]  = '0;
      assign in_top[g]    = '0;
      assign in_bottom[g] = '0;
    end
  end

  zone_qualify #(
    .COORD_W  (COORD_W),
    .MIN_SIZE (MIN_SIZE)
`ifdef ZONE_READER_AREA_EN
    , .MIN_AREA (MIN_AREA)
`endif
  ) u_qualify (
    .active  (snap_active[idx]),
    .left    (snap_left[idx]),
    .right   (snap_right[idx]),
    .top     (snap_top[idx]),
    .bottom  (snap_bottom[idx]),
    .qualify (q_ok),
    .cx      (q_cx),
    .cy      (q_cy),
    .width   (q_w),
    .height  (q_h)
`ifdef ZONE_READER_AREA_EN
    , .area  (q_area)
`endif
  );

  assign last = (idx == LAST_IDX);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (frame_done) state_nxt = SCAN;
      SCAN: begin
        if (q_ok)      state_nxt = EMIT;
        else if (last) state_nxt = DONE;
      end
      EMIT: if (out_ready) state_nxt = last ? DONE : SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      count       <= '0;
      snap_active <= '0;
      snap_left   <= '{default: '0};
      snap_right  <= '{default: '0};
      snap_top    <= '{default: '0};
      snap_bottom <= '{default: '0};
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_cx      <= '0;
      out_cy      <= '0;
      out_width   <= '0;
      out_height  <= '0;
`ifdef ZONE_READER_AREA_EN
      out_area    <= '0;
`endif
      zone_count  <= '0;
      overrun     <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= frame_done && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_done) begin
            snap_active <= in_active;
            snap_left   <= in_left;
            snap_right  <= in_right;
            snap_top    <= in_top;
            snap_bottom <= in_bottom;
            idx         <= '0;
            count       <= '0;
          end
        end
        SCAN: begin
          if (q_ok) begin
            out_valid  <= 1'b1;
            out_index  <= idx;
            out_cx     <= q_cx;
            out_cy     <= q_cy;
            out_width  <= q_w;
            out_height <= q_h;
`ifdef ZONE_READER_AREA_EN
            out_area   <= q_area;
`endif
            count      <= count + 5'd1;
          end else if (!last) begin
            idx <= idx + 4'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!last) idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
      // count is final on entry to DONE, so zone_count is valid alongside done
      if (state != DONE && state_nxt == DONE) zone_count <= count;
    end
  end

endmodule

// File: tb/tb_zone_reader.sv
module tb_zone_reader;
  localparam int N        = 4;
  localparam int CW       = 11;
  localparam int MIN_SIZE = 4;
  localparam int MIN_AREA = 64;

  logic            clk = 1'b0;
  logic            reset, frame_done, out_ready;
  logic [N-1:0]    zone_active;
  logic [N*CW-1:0] zone_left, zone_right, zone_top, zone_bottom;
  logic            out_valid;
  logic [3:0]      out_index;
  logic [CW-1:0]   out_cx, out_cy, out_width, out_height;
  logic            busy, done, overrun;
  logic [4:0]      zone_count;
`ifdef ZONE_READER_AREA_EN
  logic [2*CW-1:0] out_area;
`endif

  zone_reader #(.NUM_ZONES(N), .MIN_SIZE(MIN_SIZE), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done),
    .zone_active(zone_active), .zone_left(zone_left), .zone_right(zone_right),
    .zone_top(zone_top), .zone_bottom(zone_bottom),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_cx(out_cx), .out_cy(out_cy), .out_width(out_width), .out_height(out_height),
`ifdef ZONE_READER_AREA_EN
    .out_area(out_area),
`endif
    .busy(busy), .done(done), .zone_count(zone_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {int idx; int cx; int cy; int w; int h; int area;} rec_t;

  int   checks = 0;
  int   errors = 0;
  int   z_act[N], z_l[N], z_r[N], z_t[N], z_b[N];
  rec_t exp_q[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pack_rec(input int idx, input int cx, input int cy,
                                           input int w, input int h, input int area);
`ifdef ZONE_READER_AREA_EN
    return 80'({4'(idx), CW'(cx), CW'(cy), CW'(w), CW'(h), (2*CW)'(area)});
`else
    return 80'({4'(idx), CW'(cx), CW'(cy), CW'(w), CW'(h)}) + 80'(area * 0);
`endif
  endfunction

  function automatic logic [79:0] obs_rec();
`ifdef ZONE_READER_AREA_EN
    return pack_rec(int'(out_index), int'(out_cx), int'(out_cy), int'(out_width),
                    int'(out_height), int'(out_area));
`else
    return pack_rec(int'(out_index), int'(out_cx), int'(out_cy), int'(out_width),
                    int'(out_height), 0);
`endif
  endfunction

  task automatic push_zones();
    for (int i = 0; i < N; i++) begin
      zone_active[i]           = (z_act[i] != 0);
      zone_left[i*CW +: CW]    = CW'(z_l[i]);
      zone_right[i*CW +: CW]   = CW'(z_r[i]);
      zone_top[i*CW +: CW]     = CW'(z_t[i]);
      zone_bottom[i*CW +: CW]  = CW'(z_b[i]);
    end
  endtask

  task automatic set_zone(input int i, input int a, input int l, input int r,
                          input int t, input int b);
    z_act[i] = a; z_l[i] = l; z_r[i] = r; z_t[i] = t; z_b[i] = b;
  endtask

  task automatic rand_zone(input int i);
    int tmp;
    z_act[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
    z_l[i]   = $urandom_range(0, 2047);
    z_t[i]   = $urandom_range(0, 2047);
    if ($urandom_range(0, 3) == 0) z_r[i] = $urandom_range(0, 2047);
    else begin
      tmp = z_l[i] + $urandom_range(0, 40);
      z_r[i] = (tmp > 2047) ? 2047 : tmp;
    end
    if ($urandom_range(0, 3) == 0) z_b[i] = $urandom_range(0, 2047);
    else begin
      tmp = z_t[i] + $urandom_range(0, 40);
      z_b[i] = (tmp > 2047) ? 2047 : tmp;
    end
  endtask

  // Reference: which zones produce a record and what the record holds
  function automatic void build_expected();
    rec_t r;
    bit   ok;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      ok = (z_act[i] != 0) && (z_r[i] >= z_l[i]) && (z_b[i] >= z_t[i]) &&
           (z_r[i] - z_l[i] >= MIN_SIZE) && (z_b[i] - z_t[i] >= MIN_SIZE);
      r.idx  = i;
      r.cx   = (z_l[i] + z_r[i]) / 2;
      r.cy   = (z_t[i] + z_b[i]) / 2;
      r.w    = z_r[i] - z_l[i];
      r.h    = z_b[i] - z_t[i];
      r.area = r.w * r.h;
`ifdef ZONE_READER_AREA_EN
      if (r.area < MIN_AREA) ok = 0;
`endif
      if (ok) exp_q.push_back(r);
    end
  endfunction

  // mode 0: ready always high; 1: random ready; 2: first record stalled 5 cycles
  task automatic run_frame(input string tag, input int mode, input bit inj_emit, input bit inj_done);
    int n_exp, cyc, got, stalls, stall_run, first_cyc;
    bit seen_done, pend_ovr, injected, hs;
    build_expected();
    n_exp = exp_q.size();
    push_zones();
    frame_done = 1'b1;
    out_ready  = 1'b0;
    tick();
    frame_done = 1'b0;
    for (int i = 0; i < N; i++) rand_zone(i);
    push_zones();
    chk({tag, "_busy_start"}, busy, 1'b1);
    cyc = 0; got = 0; stalls = 0; stall_run = 0; first_cyc = -1;
    seen_done = 0; pend_ovr = 0; injected = 0;
    while (!seen_done && cyc < 400) begin
      chk({tag, "_overrun"}, overrun, pend_ovr);
      pend_ovr = 0;
      if (done) begin
        seen_done = 1;
      end else begin
        chk({tag, "_busy"}, busy, 1'b1);
        if (out_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (got < n_exp)
            chk({tag, "_record"}, obs_rec(),
                pack_rec(exp_q[got].idx, exp_q[got].cx, exp_q[got].cy,
                         exp_q[got].w, exp_q[got].h, exp_q[got].area));
          else
            chk({tag, "_extra_record"}, got, n_exp - 1);
          case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (got == 0 && stall_run < 5) ? 1'b0 : 1'b1;
          endcase
          if (!out_ready) begin
            stalls++;
            stall_run++;
          end
        end else begin
          out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hs = out_valid && out_ready;
        if (inj_emit && out_valid && !injected) begin
          frame_done = 1'b1;
          injected   = 1;
          pend_ovr   = 1;
        end
        tick();
        cyc++;
        frame_done = 1'b0;
        if (hs) begin
          got++;
          chk({tag, "_gap_after_accept"}, out_valid, 1'b0);
        end
      end
    end
    chk({tag, "_done_seen"}, seen_done, 1'b1);
    if (seen_done) begin
      chk({tag, "_busy_in_done"}, busy, 1'b1);
      chk({tag, "_latency"}, cyc, N + n_exp + stalls);
      chk({tag, "_zone_count"}, zone_count, 5'(n_exp));
      chk({tag, "_records"}, got, n_exp);
      if (n_exp > 0) chk({tag, "_first_valid"}, first_cyc, exp_q[0].idx + 1);
      if (inj_done) frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk({tag, "_overrun_after_done"}, overrun, inj_done);
      chk({tag, "_done_pulse"}, done, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_count_hold"}, zone_count, 5'(n_exp));
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; frame_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_zone(i, 0, 0, 0, 0, 0);
    push_zones();
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", zone_count, 5'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_fields", {out_index, out_cx, out_cy, out_width, out_height}, 48'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // single record from zone 0
    set_zone(0, 1, 100, 140, 50, 90);
    for (int i = 1; i < N; i++) set_zone(i, 0, 200, 260, 200, 260);
    run_frame("t1", 0, 0, 0);
    chk("t1_index", out_index, 4'd0);
    chk("t1_cx", out_cx, 11'd120);
    chk("t1_cy", out_cy, 11'd70);
    chk("t1_w", out_width, 11'd40);
    chk("t1_h", out_height, 11'd40);

    // all zones qualify, first record back-pressured
    for (int i = 0; i < N; i++) set_zone(i, 1, 10 + 100*i, 22 + 101*i, 30 + 50*i, 45 + 52*i);
    run_frame("t2", 2, 0, 0);

    // undersized and inverted zones are skipped
    set_zone(0, 1, 5, 25, 5, 25);
    set_zone(1, 1, 300, 303, 10, 50);
    set_zone(2, 1, 20, 10, 10, 50);
    set_zone(3, 1, 400, 440, 500, 530);
    run_frame("t3", 1, 0, 0);

    // degenerate boxes at the coordinate limit: nothing qualifies
    for (int i = 0; i < N; i++) set_zone(i, 1, 2047, 2047, 2047, 2047);
    run_frame("t4", 0, 0, 0);

    // centre near the top of the range needs the carry bit
    set_zone(0, 1, 2000, 2047, 1990, 2047);
    for (int i = 1; i < N; i++) set_zone(i, 0, 0, 50, 0, 50);
    run_frame("t4b", 0, 0, 0);
    chk("t4b_cx", out_cx, 11'd2023);
    chk("t4b_cy", out_cy, 11'd2018);

    // frame_done during EMIT and during DONE
    for (int i = 0; i < N; i++) rand_zone(i);
    set_zone(0, 1, 600, 650, 300, 360);
    run_frame("t5", 1, 1, 0);
    set_zone(0, 1, 100, 140, 50, 90);
    run_frame("t6", 0, 0, 1);

    // reset while a record is waiting
    set_zone(0, 1, 100, 140, 50, 90);
    for (int i = 1; i < N; i++) set_zone(i, 1, 700, 760, 100, 160);
    push_zones();
    frame_done = 1'b1; out_ready = 1'b0;
    tick();
    frame_done = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid) seen = 1;
      else tick();
    end
    chk("t7_reached_emit", seen, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_count", zone_count, 5'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t7_no_done", {done, busy}, 2'b00);
      tick();
    end
    set_zone(0, 0, 0, 0, 0, 0);
    set_zone(2, 1, 40, 90, 40, 90);
    run_frame("t7_clean", 0, 0, 0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) rand_zone(i);
      run_frame("rnd", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zone_reader.md
Name: zone_reader

Overview:
- Consumer side of the zone tracker bank: at end of frame, snapshots the bounding boxes of all tracker zones and emits one record per qualifying zone over a valid/ready stream.
- Each record carries the zone centre and size, for downstream cursor/gesture logic.
- Sits between the zone tracker chain (pixel domain, same clock) and the pointer controller.

Parameters:
- NUM_ZONES, 4, number of tracker zones read each frame (1..16).
- MIN_SIZE, 4, minimum width and height, in pixels, for a zone to be reported.
- COORD_W, 11, coordinate width; matches tracker hcount/vcount bounds.

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  synchronous, active-high reset.
- frame_done  input  1  one-cycle pulse after the last pixel of a frame; asserted before the trackers are cleared.
- zone_active  input  NUM_ZONES  per-zone tracker state; bit i = 1 when zone i is ACTIVE.
- zone_left  input  NUM_ZONES*COORD_W  flattened left bounds; zone i occupies bits [i*COORD_W +: COORD_W].
- zone_right  input  NUM_ZONES*COORD_W  flattened right bounds.
- zone_top  input  NUM_ZONES*COORD_W  flattened top bounds.
- zone_bottom  input  NUM_ZONES*COORD_W  flattened bottom bounds.
- out_valid  output  1  record valid.
- out_ready  input  1  downstream accepts the record.
- out_index  output  4  zone index of the record.
- out_cx  output  COORD_W  (left+right)>>1.
- out_cy  output  COORD_W  (top+bottom)>>1.
- out_width  output  COORD_W  right-left.
- out_height  output  COORD_W  bottom-top.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the frame's readout completes.
- zone_count  output  5  records emitted in the last completed readout; updates with done.
- overrun  output  1  one-cycle pulse when frame_done arrives while busy.

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot registers 0.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On frame_done, register all zone_* inputs into snapshot registers on the same edge.
  - Clear idx and the record count; go to SCAN.
  - Inputs are not sampled after this edge.
- SCAN (one cycle per zone):
  - Zone idx qualifies when all hold: active bit = 1, right >= left, bottom >= top, right-left >= MIN_SIZE, bottom-top >= MIN_SIZE.
  - If it qualifies: load out_* registers, out_valid <= 1, increment count, go to EMIT.
  - If it does not qualify: go to DONE when idx == NUM_ZONES-1, else idx++ and stay in SCAN.
- EMIT:
  - out_valid and out_* hold stable until out_valid && out_ready.
  - On the handshake edge: out_valid <= 0; go to DONE when idx == NUM_ZONES-1, else idx++ and go to SCAN.
  - Back-to-back records are therefore separated by at least one idle cycle.
- DONE: done = 1 and zone_count <= count for exactly one cycle; then go to IDLE.
- Arithmetic:
  - Centre sums are computed at COORD_W+1 bits before the shift, so there is no overflow at 2047+2047.
  - Width and height are computed only when the ordering check passes; inverted boxes are skipped, never wrapped.
- frame_done while busy: ignored for readout; overrun pulses for one cycle; the in-flight readout continues unchanged.
- frame_done in the DONE cycle: counts as busy and raises overrun.
- Reset mid-readout: immediate IDLE; out_valid drops; no done pulse.
- No qualifying zones: runs NUM_ZONES SCAN cycles, then DONE with zone_count = 0.
- Latency: frame_done to first out_valid = 2 cycles when zone 0 qualifies.

Optional Feature:
- Macro: ZONE_READER_AREA_EN.
- When defined:
  - Adds port out_area, output, 2*COORD_W bits, equal to width*height, registered with the other out_* fields in SCAN.
  - Adds parameter MIN_AREA (default 64); zones with area < MIN_AREA are also skipped.
- When undefined: port, multiplier and check are absent; behaviour is otherwise identical.

Decomposition:
- Shared package zone_pkg holds:
  - COORD_W, MAX_X = 800, MAX_Y = 600;
  - tracker state encodings INACTIVE = 0, ACTIVE = 1;
  - the reader state enum.
- One sub-module, zone_qualify: purely combinational. Takes one zone's bounds and active bit; returns qualify, cx, cy, width, height (and area under the macro). The reader instantiates it once, fed by the idx mux.

Test Plan:
- Zone0 active, L=100 R=140 T=50 B=90; others inactive; out_ready=1 -> one record: index 0, cx 120, cy 70, w 40, h 40; done pulse; zone_count 1.
- All 4 zones active and valid; out_ready low for 5 cycles on the first record -> out_* stable throughout; records appear in order 0,1,2,3; zone_count 4.
- Zone1 with w=3 (< MIN_SIZE) and zone2 with R=10 L=20 -> both skipped; no wrapped width emitted.
- L=R=2047, T=B=2047, active -> cx 2047, cy 2047; w 0 is rejected since 0 < MIN_SIZE; zone_count 0; done after 4 SCAN cycles.
- Second frame_done during EMIT -> overrun for 1 cycle; the current readout completes normally; no restart.
- Reset asserted mid-EMIT -> next cycle out_valid 0, busy 0, no done; a following frame_done starts a clean readout.
